// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds the default data and register-index widths, plus the grant
// encoding produced by the two-requester round-robin arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int ADDR_REG_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter.
//   alu_*   : ALU write-back request (valid/rd/data in, ready out)
//   lsu_*   : load-unit write-back request (valid/rd/data in, ready out)
//   issue_* : destination reservation of a newly issued instruction
//   rs1/rs2 : decode-stage source indices, hazard back out
//   rf_*    : register-file write port
// slave is the arbiter side, master the pipeline side.
interface regfile_wb_arbiter_if #(
  parameter int Data_Width   = regfile_wb_arbiter_pkg::DATA_WIDTH_DEF,
  parameter int AddrRegWidth = regfile_wb_arbiter_pkg::ADDR_REG_WIDTH_DEF
) ();

  logic                    alu_valid;
  logic [AddrRegWidth-1:0] alu_rd;
  logic [Data_Width-1:0]   alu_data;
  logic                    alu_ready;

  logic                    lsu_valid;
  logic [AddrRegWidth-1:0] lsu_rd;
  logic [Data_Width-1:0]   lsu_data;
  logic                    lsu_ready;

  logic                    issue_en;
  logic [AddrRegWidth-1:0] issue_rd;
  logic [AddrRegWidth-1:0] rs1;
  logic [AddrRegWidth-1:0] rs2;
  logic                    hazard;

  logic                    rf_en;
  logic [AddrRegWidth-1:0] rf_rd;
  logic [Data_Width-1:0]   rf_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_en, issue_rd, rs1, rs2,
    output hazard,
    output rf_en, rf_rd, rf_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_en, issue_rd, rs1, rs2,
    input  hazard,
    input  rf_en, rf_rd, rf_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter (ALU vs LSU).
// Ports: clk, rst (async active-low), alu_valid, lsu_valid in;
// grant out (combinational). The pointer remembers the last granted
// requester and only moves when a grant is issued.
//
// last_q     | meaning
// GRANT_NONE | no grant since reset, LSU wins a tie
// GRANT_ALU  | ALU granted last, LSU wins a tie
// GRANT_LSU  | LSU granted last, ALU wins a tie
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   alu_valid,
  input  logic   lsu_valid,
  output grant_e grant
);

  grant_e last_q;
  grant_e last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= GRANT_NONE;
    else      last_q <= last_d;
  end

  // ready equals grant, so every grant is a transfer; reset masks grants.
  always_comb begin
    grant  = GRANT_NONE;
    last_d = last_q;
    if (rst) begin
      if (alu_valid && lsu_valid)
        grant = (last_q == GRANT_LSU) ? GRANT_ALU : GRANT_LSU;
      else if (alu_valid)
        grant = GRANT_ALU;
      else if (lsu_valid)
        grant = GRANT_LSU;
    end
    if (grant != GRANT_NONE) last_d = grant;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with destination scoreboard.
// Ports: clk, rst (async active-low), bus (regfile_wb_arbiter_if.slave).
// One of ALU/LSU write-backs is accepted per cycle (round robin) and
// registered onto the rf_* write port. A busy bit per register is set
// on issue and cleared on accept; hazard flags pending sources.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int Data_Width   = DATA_WIDTH_DEF,
  parameter int AddrRegWidth = ADDR_REG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int NumRegs = 2 ** AddrRegWidth;

  grant_e                  grant;
  logic                    xfer;
  logic [AddrRegWidth-1:0] xfer_rd;
  logic [Data_Width-1:0]   xfer_data;

  logic [NumRegs-1:0]      busy_q, busy_d;
  logic                    rf_en_q, rf_en_d;
  logic [AddrRegWidth-1:0] rf_rd_q, rf_rd_d;
  logic [Data_Width-1:0]   rf_data_q, rf_data_d;

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (bus.alu_valid),
    .lsu_valid (bus.lsu_valid),
    .grant     (grant)
  );

  assign bus.alu_ready = (grant == GRANT_ALU);
  assign bus.lsu_ready = (grant == GRANT_LSU);

  always_comb begin
    xfer      = 1'b0;
    xfer_rd   = '0;
    xfer_data = '0;
    if (grant == GRANT_ALU) begin
      xfer      = 1'b1;
      xfer_rd   = bus.alu_rd;
      xfer_data = bus.alu_data;
    end else if (grant == GRANT_LSU) begin
      xfer      = 1'b1;
      xfer_rd   = bus.lsu_rd;
      xfer_data = bus.lsu_data;
    end
  end

  // Clear before set so a same-edge issue to the same index keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (xfer) busy_d[xfer_rd] = 1'b0;
    if (bus.issue_en && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Writes to x0 are accepted but dropped; rd/data hold while idle.
  always_comb begin
    rf_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (xfer && (xfer_rd != '0)) begin
      rf_en_d   = 1'b1;
      rf_rd_d   = xfer_rd;
      rf_data_d = xfer_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.hazard = ((bus.rs1 != '0) && busy_q[bus.rs1]) ||
                      ((bus.rs2 != '0) && busy_q[bus.rs2]);

  assign bus.rf_en   = rf_en_q;
  assign bus.rf_rd   = rf_rd_q;
  assign bus.rf_data = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_en  = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b0;
    #2;
    chk("rst_rf_en",   32'(bus.rf_en),   32'h0);
    chk("rst_rf_rd",   32'(bus.rf_rd),   32'h0);
    chk("rst_rf_data", bus.rf_data,      32'h0);
    chk("rst_hazard",  32'(bus.hazard),  32'h0);
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    #1;
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'h0);
    step();
    do_reset();

    // Round robin from a fresh reset, both valid after 4 idle cycles.
    for (int i = 0; i < 4; i++) step();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h1111_0003;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h2222_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_lsu_ready_%0d", i), 32'(bus.lsu_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr_alu_ready_%0d", i), 32'(bus.alu_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
      step();
      chk($sformatf("rr_rf_en_%0d", i),   32'(bus.rf_en), 32'h1);
      chk($sformatf("rr_rf_rd_%0d", i),   32'(bus.rf_rd), (i % 2 == 0) ? 32'd3 : 32'd4);
      chk($sformatf("rr_rf_data_%0d", i), bus.rf_data,
          (i % 2 == 0) ? 32'h1111_0003 : 32'h2222_0004);
    end

    // Idle cycles must not move the pointer: ALU was last, LSU next.
    idle_inputs();
    step();
    step();
    step();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h1111_0003;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h2222_0004;
    #1;
    chk("idle_ptr_lsu_ready", 32'(bus.lsu_ready), 32'h1);
    chk("idle_ptr_alu_ready", 32'(bus.alu_ready), 32'h0);
    step();
    idle_inputs();

    // Single ALU request, registered with one-cycle latency.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    chk("alu_only_ready",     32'(bus.alu_ready), 32'h1);
    chk("alu_only_lsu_ready", 32'(bus.lsu_ready), 32'h0);
    step();
    idle_inputs();
    chk("alu_only_rf_en",   32'(bus.rf_en), 32'h1);
    chk("alu_only_rf_rd",   32'(bus.rf_rd), 32'd5);
    chk("alu_only_rf_data", bus.rf_data,    32'hDEAD_BEEF);
    step();
    chk("idle_rf_en",      32'(bus.rf_en), 32'h0);
    chk("hold_rf_rd",      32'(bus.rf_rd), 32'd5);
    chk("hold_rf_data",    bus.rf_data,    32'hDEAD_BEEF);

    // Scoreboard: reserve x7, hazard until the cycle after LSU accept.
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    step();
    bus.issue_en = 1'b0;
    bus.rs1 = 5'd7;
    #1;
    chk("haz7_set", 32'(bus.hazard), 32'h1);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0777;
    #1;
    chk("haz7_lsu_ready",  32'(bus.lsu_ready), 32'h1);
    chk("haz7_no_bypass",  32'(bus.hazard),    32'h1);
    step();
    bus.lsu_valid = 1'b0;
    chk("haz7_cleared", 32'(bus.hazard), 32'h0);
    bus.rs1 = 5'd0;

    // Same-edge issue and ALU write to x9: set wins.
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0999;
    bus.rs2 = 5'd9;
    #1;
    chk("haz9_before", 32'(bus.hazard), 32'h0);
    step();
    bus.issue_en = 1'b0; bus.alu_valid = 1'b0;
    chk("haz9_set_wins", 32'(bus.hazard), 32'h1);
    chk("haz9_rf_rd",    32'(bus.rf_rd),  32'd9);
    step();
    chk("haz9_stays", 32'(bus.hazard), 32'h1);
    bus.rs2 = 5'd0;

    // Writes to x0 are accepted but never reach the register file.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234_5678;
    #1;
    chk("x0_alu_ready", 32'(bus.alu_ready), 32'h1);
    step();
    bus.alu_valid = 1'b0;
    chk("x0_rf_en",      32'(bus.rf_en), 32'h0);
    chk("x0_hold_rf_rd", 32'(bus.rf_rd), 32'd9);
    chk("x0_hold_data",  bus.rf_data,    32'h0000_0999);
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
    step();
    bus.issue_en = 1'b0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1;
    chk("x0_no_hazard", 32'(bus.hazard), 32'h0);

    // Reset in the cycle after an accept discards the write.
    bus.issue_en = 1'b1; bus.issue_rd = 5'd15;
    step();
    bus.issue_en = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hCAFE_0012;
    step();
    bus.alu_valid = 1'b0;
    bus.rs1 = 5'd15;
    #1;
    chk("mid_rst_pre_rf_en",  32'(bus.rf_en),  32'h1);
    chk("mid_rst_pre_hazard", 32'(bus.hazard), 32'h1);
    rst = 1'b0;
    bus.alu_valid = 1'b1;
    #1;
    chk("mid_rst_rf_en",     32'(bus.rf_en),     32'h0);
    chk("mid_rst_rf_rd",     32'(bus.rf_rd),     32'h0);
    chk("mid_rst_hazard",    32'(bus.hazard),    32'h0);
    chk("mid_rst_alu_ready", 32'(bus.alu_ready), 32'h0);
    step();
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_rf_en_%0d", i), 32'(bus.rf_en), 32'h0);
    end
    chk("post_rst_hazard", 32'(bus.hazard), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
